axil_slave_regfile: RTL and testbench
=====================================

// Module: axil_slave_regfile
// PURPOSE
//   AXI4-Lite slave (responder) register file: the completer end of the AXI-Lite link driven by
//   the master agent. Holds NUM_REGS word-wide control registers, accepts single-beat writes with
//   byte strobes and serves single-beat reads. Exposes register contents and write pulses to
//   fabric logic. Sits behind the passthrough VIP inside the chip block design.
// PARAMETERS
//   ADDR_WIDTH  12  byte-address width of AW/AR channels
//   DATA_WIDTH  32  data width; only 32 is supported (4 strobe bits)
//   NUM_REGS    16  number of registers; power of two, NUM_REGS*4 <= 2**ADDR_WIDTH
// PORTS
//   aclk            in   1                    clock
//   aresetn         in   1                    asynchronous active-low reset
//   s_axil_awaddr   in   ADDR_WIDTH           write address
//   s_axil_awvalid  in   1                    write address valid
//   s_axil_awready  out  1                    write address ready
//   s_axil_wdata    in   DATA_WIDTH           write data
//   s_axil_wstrb    in   DATA_WIDTH/8         write byte strobes
//   s_axil_wvalid   in   1                    write data valid
//   s_axil_wready   out  1                    write data ready
//   s_axil_bresp    out  2                    write response
//   s_axil_bvalid   out  1                    write response valid
//   s_axil_bready   in   1                    write response ready
//   s_axil_araddr   in   ADDR_WIDTH           read address
//   s_axil_arvalid  in   1                    read address valid
//   s_axil_arready  out  1                    read address ready
//   s_axil_rdata    out  DATA_WIDTH           read data
//   s_axil_rresp    out  2                    read response
//   s_axil_rvalid   out  1                    read data valid
//   s_axil_rready   in   1                    read data ready
//   reg_q           out  NUM_REGS*DATA_WIDTH  register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_wr_stb      out  NUM_REGS             one-cycle pulse, register i was written
// BEHAVIOUR
//   Reset (aresetn=0, async): all registers, bvalid, rvalid, reg_wr_stb, rdata, bresp, rresp = 0;
//     awready=wready=arready=0 while in reset, 1 in the first cycle after release.
//   Register index = addr[$clog2(NUM_REGS)+1:2]; addr[1:0] ignored; addr bits above the register
//     window non-zero => out of range.
//   Write FSM states W_IDLE, W_RESP. In W_IDLE, AW and W are captured independently:
//     awready=1 until an AW is held, wready=1 until a W is held (either order, or same cycle).
//     Cycle after both are held: update bytes where wstrb=1, pulse reg_wr_stb[idx], set bvalid,
//     drop awready/wready, enter W_RESP. Write-to-bvalid latency = 1 cycle after the later handshake.
//   W_RESP: hold bvalid/bresp stable until bready; on handshake clear bvalid, clear held flags,
//     return to W_IDLE with awready=wready=1 next cycle. No second write accepted before B completes.
//   Read FSM states R_IDLE, R_DATA. R_IDLE: arready=1; on handshake latch rdata/rresp, rvalid=1 next
//     cycle, arready=0, enter R_DATA. R_DATA: hold rdata/rresp/rvalid stable until rready, then
//     return to R_IDLE.
//   Read and write channels are fully independent and may complete in the same cycle.
//   Read sampled in the same cycle a write updates the same register returns the OLD value.
//   wstrb=0 write: register unchanged, reg_wr_stb still pulses, bresp=OKAY.
//   Out-of-range write: no register change, no reg_wr_stb; out-of-range read: rdata=0.
//   Async reset mid-transaction: pending AW/W/AR dropped, no response issued.
// CONFIGURATION
//   AXIL_SLV_DECERR_EN defined: out-of-range accesses return bresp/rresp = 2'b11 (DECERR).
//   Not defined: out-of-range accesses return 2'b00 (OKAY), silently ignored. In-range always OKAY.
// STRUCTURE
//   Package axil_slv_pkg: resp_t enum (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11), wr_state_t,
//     rd_state_t, localparam STRB_WIDTH = DATA_WIDTH/8.
//   Sub-module axil_slv_wr_ctrl (AW/W capture + B channel FSM); read path and register array inline.
// TESTING
//   1 AW then W 3 cycles later, addr 0x008, data 0xDEADBEEF, strb 0xF -> bvalid 1 cycle after W,
//     bresp=0, reg_q reg2=0xDEADBEEF, reg_wr_stb[2] single pulse.
//   2 W before AW, strb 0x3, data 0x12345678 to reg2 above -> reg2=0xDEAD5678; then read 0x008 ->
//     rvalid 1 cycle after AR handshake, rdata=0xDEAD5678, rresp=0.
//   3 bready held low 5 cycles -> bvalid/bresp stable, awready=wready=0 throughout, new AW stalls.
//   4 Read 0x004 and write 0x004=0xA5A5A5A5 handshaking same cycle (reg1=0) -> rdata=0,
//     later read returns 0xA5A5A5A5.
//   5 Write/read 0x800 (NUM_REGS=16) -> no reg change, rdata=0; resp 2'b11 with AXIL_SLV_DECERR_EN,
//     2'b00 without.
//   6 Assert aresetn=0 with AW held, W pending -> all outputs 0, registers 0, no bvalid after release.

Source files
------------

// File: rtl/axil_slv_pkg.sv
// Shared types and constants for the AXI4-Lite slave register file.
// Build option AXIL_SLV_DECERR_EN: out-of-range accesses answer DECERR instead of OKAY.
package axil_slv_pkg;

  localparam int AXIL_DATA_WIDTH = 32;
  localparam int STRB_WIDTH      = AXIL_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

`ifdef AXIL_SLV_DECERR_EN
  localparam resp_t ERR_RESP = DECERR;
`else
  localparam resp_t ERR_RESP = OKAY;
`endif

  // An address hits the register window when every bit above the index field is zero.
  function automatic logic addr_hit(input logic [31:0] addr, input int idx_w);
    return (addr >> (idx_w + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/axil_slv_wr_ctrl.sv
// AXI4-Lite write-side control: independent AW/W capture, commit strobe and B channel.
// Response code for out-of-range writes follows AXIL_SLV_DECERR_EN (see axil_slv_pkg).
module axil_slv_wr_ctrl
  import axil_slv_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_REGS   = 16,
  localparam int IDX_W     = $clog2(NUM_REGS)
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [ADDR_WIDTH-1:0]      awaddr,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [AXIL_DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0]      wstrb,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  output logic                       wr_en,
  output logic [IDX_W-1:0]           wr_idx,
  output logic [AXIL_DATA_WIDTH-1:0] wr_data,
  output logic [STRB_WIDTH-1:0]      wr_strb
);

  wr_state_t state, state_n;

  logic                       aw_held, w_held;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [AXIL_DATA_WIDTH-1:0] data_q;
  logic [STRB_WIDTH-1:0]      strb_q;

  logic                       aw_hs, w_hs, have_aw, have_w, commit, hit;
  logic [ADDR_WIDTH-1:0]      cur_addr;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= W_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      W_IDLE:  if (commit) state_n = W_RESP;
      W_RESP:  if (bready) state_n = W_IDLE;
      default: state_n = W_IDLE;
    endcase
  end

  // The commit uses whichever of AW/W is arriving this cycle or was captured earlier.
  always_comb begin
    aw_hs    = awvalid && awready;
    w_hs     = wvalid && wready;
    have_aw  = aw_held || aw_hs;
    have_w   = w_held || w_hs;
    commit   = (state == W_IDLE) && have_aw && have_w;
    cur_addr = aw_held ? addr_q : awaddr;
    wr_data  = w_held ? data_q : wdata;
    wr_strb  = w_held ? strb_q : wstrb;
    hit      = addr_hit(32'(cur_addr), IDX_W);
    wr_en    = commit && hit;
    wr_idx   = cur_addr[IDX_W+1:2];
    bvalid   = (state == W_RESP);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bresp   <= OKAY;
    end else begin
      case (state)
        W_IDLE: begin
          if (commit) begin
            aw_held <= 1'b1;
            w_held  <= 1'b1;
            awready <= 1'b0;
            wready  <= 1'b0;
            bresp   <= hit ? OKAY : ERR_RESP;
          end else begin
            if (aw_hs) begin
              aw_held <= 1'b1;
              addr_q  <= awaddr;
            end
            if (w_hs) begin
              w_held <= 1'b1;
              data_q <= wdata;
              strb_q <= wstrb;
            end
            awready <= !have_aw;
            wready  <= !have_w;
          end
        end
        W_RESP: begin
          if (bready) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave register file: NUM_REGS word registers with byte-strobed writes and a read channel.
// Build option AXIL_SLV_DECERR_EN: out-of-range accesses answer DECERR instead of OKAY.
module axil_slave_regfile
  import axil_slv_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
  input  logic                           s_axil_awvalid,
  output logic                           s_axil_awready,
  input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axil_wstrb,
  input  logic                           s_axil_wvalid,
  output logic                           s_axil_wready,
  output logic [1:0]                     s_axil_bresp,
  output logic                           s_axil_bvalid,
  input  logic                           s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
  input  logic                           s_axil_arvalid,
  output logic                           s_axil_arready,
  output logic [DATA_WIDTH-1:0]          s_axil_rdata,
  output logic [1:0]                     s_axil_rresp,
  output logic                           s_axil_rvalid,
  input  logic                           s_axil_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_stb
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0]      regs [NUM_REGS];

  logic                       wr_en;
  logic [IDX_W-1:0]           wr_idx;
  logic [AXIL_DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0]      wr_strb;

  rd_state_t                  rd_state, rd_state_n;
  logic                       ar_hs, rd_hit;
  logic [IDX_W-1:0]           rd_idx;

  axil_slv_wr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_wr_ctrl (
    .aclk    (aclk),
    .aresetn (aresetn),
    .awaddr  (s_axil_awaddr),
    .awvalid (s_axil_awvalid),
    .awready (s_axil_awready),
    .wdata   (s_axil_wdata),
    .wstrb   (s_axil_wstrb),
    .wvalid  (s_axil_wvalid),
    .wready  (s_axil_wready),
    .bresp   (s_axil_bresp),
    .bvalid  (s_axil_bvalid),
    .bready  (s_axil_bready),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_strb (wr_strb)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wr_stb <= '0;
    end else begin
      reg_wr_stb <= '0;
      if (wr_en) begin
        reg_wr_stb[wr_idx] <= 1'b1;
        for (int b = 0; b < STRB_WIDTH; b++)
          if (wr_strb[b]) regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rd_state <= R_IDLE;
    else          rd_state <= rd_state_n;
  end

  always_comb begin
    rd_state_n = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_state_n = R_DATA;
      R_DATA:  if (s_axil_rready) rd_state_n = R_IDLE;
      default: rd_state_n = R_IDLE;
    endcase
  end

  always_comb begin
    ar_hs         = s_axil_arvalid && s_axil_arready;
    rd_hit        = addr_hit(32'(s_axil_araddr), IDX_W);
    rd_idx        = s_axil_araddr[IDX_W+1:2];
    s_axil_rvalid = (rd_state == R_DATA);
  end

  // Read data is sampled from the pre-edge array, so a same-cycle write is not visible yet.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axil_arready <= 1'b0;
      s_axil_rdata   <= '0;
      s_axil_rresp   <= OKAY;
    end else begin
      s_axil_arready <= (rd_state_n == R_IDLE);
      if (ar_hs) begin
        s_axil_rdata <= rd_hit ? regs[rd_idx] : '0;
        s_axil_rresp <= rd_hit ? OKAY : ERR_RESP;
      end
    end
  end

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Self-checking bench for axil_slave_regfile: directed scenarios, then random traffic against an array model.
// Expected out-of-range response follows AXIL_SLV_DECERR_EN.
module tb_axil_slave_regfile;

  localparam int NR = 16;

`ifdef AXIL_SLV_DECERR_EN
  localparam logic [1:0] ERR = 2'b11;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [11:0]      s_axil_awaddr = '0;
  logic             s_axil_awvalid = 1'b0;
  logic             s_axil_awready;
  logic [31:0]      s_axil_wdata = '0;
  logic [3:0]       s_axil_wstrb = '0;
  logic             s_axil_wvalid = 1'b0;
  logic             s_axil_wready;
  logic [1:0]       s_axil_bresp;
  logic             s_axil_bvalid;
  logic             s_axil_bready = 1'b0;
  logic [11:0]      s_axil_araddr = '0;
  logic             s_axil_arvalid = 1'b0;
  logic             s_axil_arready;
  logic [31:0]      s_axil_rdata;
  logic [1:0]       s_axil_rresp;
  logic             s_axil_rvalid;
  logic             s_axil_rready = 1'b0;
  logic [NR*32-1:0] reg_q;
  logic [NR-1:0]    reg_wr_stb;

  axil_slave_regfile dut (
    .aclk           (clk),
    .aresetn        (rst_n),
    .s_axil_awaddr  (s_axil_awaddr),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .s_axil_wdata   (s_axil_wdata),
    .s_axil_wstrb   (s_axil_wstrb),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bresp   (s_axil_bresp),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bready  (s_axil_bready),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready),
    .reg_q          (reg_q),
    .reg_wr_stb     (reg_wr_stb)
  );

  logic [31:0] model [NR];
  int n_checks = 0;
  int n_fail = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] regOf(input int i);
    return reg_q[i*32 +: 32];
  endfunction

  function automatic bit inRange(input logic [11:0] addr);
    return addr < 12'(NR * 4);
  endfunction

  function automatic void modelWrite(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    if (!inRange(addr)) return;
    idx = addr / 4;
    for (int b = 0; b < 4; b++)
      if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllRegs(input string tag);
    for (int i = 0; i < NR; i++)
      checkOutput($sformatf("%s_reg%0d", tag, i), regOf(i), model[i]);
  endtask

  task automatic applyWrite(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, input bit stall_aw);
    int cyc;
    bit aw_done, w_done, aw_fire, w_fire;
    logic [15:0] stb_exp;
    cyc = 0; aw_done = 0; w_done = 0;
    s_axil_awaddr = addr; s_axil_wdata = data; s_axil_wstrb = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      s_axil_awvalid = !aw_done && (cyc >= aw_dly);
      s_axil_wvalid  = !w_done && (cyc >= w_dly);
      aw_fire = s_axil_awvalid && s_axil_awready;
      w_fire  = s_axil_wvalid && s_axil_wready;
      checkOutput("wr_bvalid_early", 32'(s_axil_bvalid), 32'd0);
      tick();
      cyc++;
      if (aw_fire) aw_done = 1;
      if (w_fire) w_done = 1;
    end
    s_axil_awvalid = 1'b0;
    s_axil_wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      checkOutput("wr_handshake_timeout", 32'd0, 32'd1);
      return;
    end
    stb_exp = inRange(addr) ? (16'd1 << (addr / 4)) : 16'd0;
    modelWrite(addr, data, strb);
    checkOutput("wr_bvalid", 32'(s_axil_bvalid), 32'd1);
    checkOutput("wr_bresp", 32'(s_axil_bresp), inRange(addr) ? 32'd0 : 32'(ERR));
    checkOutput("wr_stb", 32'(reg_wr_stb), 32'(stb_exp));
    checkAllRegs("wr");
    s_axil_bready = (b_dly == 0);
    if (stall_aw && b_dly > 0) begin
      s_axil_awvalid = 1'b1;
      s_axil_awaddr = 12'h010;
    end
    for (int i = 0; i < b_dly; i++) begin
      tick();
      if (i == 0) checkOutput("wr_stb_single_pulse", 32'(reg_wr_stb), 32'd0);
      checkOutput("wr_bvalid_hold", 32'(s_axil_bvalid), 32'd1);
      checkOutput("wr_bresp_hold", 32'(s_axil_bresp), inRange(addr) ? 32'd0 : 32'(ERR));
      checkOutput("wr_awready_resp", 32'(s_axil_awready), 32'd0);
      checkOutput("wr_wready_resp", 32'(s_axil_wready), 32'd0);
      if (i == b_dly - 1) begin
        s_axil_bready = 1'b1;
        s_axil_awvalid = 1'b0;
      end
    end
    tick();
    s_axil_bready = 1'b0;
    if (b_dly == 0) checkOutput("wr_stb_single_pulse", 32'(reg_wr_stb), 32'd0);
    checkOutput("wr_bvalid_clear", 32'(s_axil_bvalid), 32'd0);
    checkOutput("wr_awready_back", 32'(s_axil_awready), 32'd1);
    checkOutput("wr_wready_back", 32'(s_axil_wready), 32'd1);
  endtask

  task automatic applyRead(input logic [11:0] addr, input int ar_dly, input int r_dly);
    int cyc;
    bit fired, fire;
    logic [31:0] exp_data;
    logic [1:0] exp_resp;
    cyc = 0; fired = 0;
    s_axil_araddr = addr;
    while (!fired && cyc < 50) begin
      s_axil_arvalid = (cyc >= ar_dly);
      fire = s_axil_arvalid && s_axil_arready;
      tick();
      cyc++;
      if (fire) fired = 1;
    end
    s_axil_arvalid = 1'b0;
    if (!fired) begin
      checkOutput("rd_handshake_timeout", 32'd0, 32'd1);
      return;
    end
    exp_data = inRange(addr) ? model[addr / 4] : 32'd0;
    exp_resp = inRange(addr) ? 2'b00 : ERR;
    checkOutput("rd_rvalid", 32'(s_axil_rvalid), 32'd1);
    checkOutput("rd_rdata", s_axil_rdata, exp_data);
    checkOutput("rd_rresp", 32'(s_axil_rresp), 32'(exp_resp));
    s_axil_rready = (r_dly == 0);
    for (int i = 0; i < r_dly; i++) begin
      tick();
      checkOutput("rd_rvalid_hold", 32'(s_axil_rvalid), 32'd1);
      checkOutput("rd_rdata_hold", s_axil_rdata, exp_data);
      checkOutput("rd_arready_busy", 32'(s_axil_arready), 32'd0);
      if (i == r_dly - 1) s_axil_rready = 1'b1;
    end
    tick();
    s_axil_rready = 1'b0;
    checkOutput("rd_rvalid_clear", 32'(s_axil_rvalid), 32'd0);
    checkOutput("rd_arready_back", 32'(s_axil_arready), 32'd1);
  endtask

  // Random mix of reads and writes, mostly in range, with random valid/ready delays.
  task automatic applyStimulus(input int n);
    logic [11:0] addr;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 5) == 0) addr = 12'($urandom_range(NR * 4, 4095));
      else addr = 12'($urandom_range(0, NR * 4 - 1));
      if ($urandom_range(0, 2) != 0)
        applyWrite(addr, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'b0);
      else
        applyRead(addr, $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelClear();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_awready", 32'(s_axil_awready), 32'd0);
    checkOutput("rst_wready", 32'(s_axil_wready), 32'd0);
    checkOutput("rst_arready", 32'(s_axil_arready), 32'd0);
    checkOutput("rst_bvalid", 32'(s_axil_bvalid), 32'd0);
    checkOutput("rst_rvalid", 32'(s_axil_rvalid), 32'd0);
    checkOutput("rst_stb", 32'(reg_wr_stb), 32'd0);
    checkAllRegs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("rel_awready", 32'(s_axil_awready), 32'd1);
    checkOutput("rel_wready", 32'(s_axil_wready), 32'd1);
    checkOutput("rel_arready", 32'(s_axil_arready), 32'd1);

    // AW first, W three cycles later
    applyWrite(12'h008, 32'hDEADBEEF, 4'hF, 0, 3, 0, 1'b0);
    checkOutput("t1_reg2", regOf(2), 32'hDEADBEEF);

    // W first, partial strobe, then read back
    applyWrite(12'h008, 32'h12345678, 4'h3, 2, 0, 1, 1'b0);
    checkOutput("t2_reg2", regOf(2), 32'hDEAD5678);
    applyRead(12'h008, 0, 0);

    // Back-pressured B channel with a stalled new AW
    applyWrite(12'h00C, 32'h0BAD_F00D, 4'hF, 0, 0, 5, 1'b1);

    // Read and write to reg1 handshaking in the same cycle
    s_axil_awaddr = 12'h004; s_axil_wdata = 32'hA5A5A5A5; s_axil_wstrb = 4'hF;
    s_axil_araddr = 12'h004;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
    checkOutput("t4_awready", 32'(s_axil_awready), 32'd1);
    checkOutput("t4_wready", 32'(s_axil_wready), 32'd1);
    checkOutput("t4_arready", 32'(s_axil_arready), 32'd1);
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    checkOutput("t4_rvalid", 32'(s_axil_rvalid), 32'd1);
    checkOutput("t4_rdata_old", s_axil_rdata, 32'd0);
    checkOutput("t4_bvalid", 32'(s_axil_bvalid), 32'd1);
    checkOutput("t4_stb", 32'(reg_wr_stb), 32'h0002);
    modelWrite(12'h004, 32'hA5A5A5A5, 4'hF);
    s_axil_bready = 1'b1; s_axil_rready = 1'b1;
    tick();
    s_axil_bready = 1'b0; s_axil_rready = 1'b0;
    checkOutput("t4_bvalid_clear", 32'(s_axil_bvalid), 32'd0);
    checkOutput("t4_rvalid_clear", 32'(s_axil_rvalid), 32'd0);
    checkOutput("t4_reg1", regOf(1), 32'hA5A5A5A5);
    applyRead(12'h004, 1, 2);

    // Out-of-range write and read
    applyWrite(12'h800, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 1'b0);
    applyRead(12'h800, 0, 1);

    // Async reset with AW captured and W still pending
    s_axil_awaddr = 12'h010; s_axil_awvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0;
    checkOutput("t6_aw_held", 32'(s_axil_awready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    modelClear();
    checkOutput("t6_awready", 32'(s_axil_awready), 32'd0);
    checkOutput("t6_wready", 32'(s_axil_wready), 32'd0);
    checkOutput("t6_arready", 32'(s_axil_arready), 32'd0);
    checkOutput("t6_bvalid", 32'(s_axil_bvalid), 32'd0);
    checkOutput("t6_rvalid", 32'(s_axil_rvalid), 32'd0);
    checkOutput("t6_rdata", s_axil_rdata, 32'd0);
    checkOutput("t6_bresp", 32'(s_axil_bresp), 32'd0);
    checkOutput("t6_rresp", 32'(s_axil_rresp), 32'd0);
    checkOutput("t6_stb", 32'(reg_wr_stb), 32'd0);
    checkAllRegs("t6");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("t6_rel_awready", 32'(s_axil_awready), 32'd1);
    checkOutput("t6_rel_wready", 32'(s_axil_wready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t6_no_bvalid", 32'(s_axil_bvalid), 32'd0);
    end

    applyStimulus(40);
    checkAllRegs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
